reg_mem_2r1w: RTL and testbench

- Parametrised successor register memory: one synchronous write port, two independent registered read ports (A, B).
- Built-in hardware clear sweep, started by reset or by a `clr` request, with a `busy` flag.
- Drop-in storage for datapath blocks that need two operands per cycle and a guaranteed-known memory state after reset.

---
 rtl/reg_mem_2r1w.sv | 167 ++++++++++++++++
 tb/tb_reg_mem_2r1w.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_mem_2r1w.sv
// Two-read one-write register memory with hardware clear sweep.
// Optional per-word even parity under REG_MEM_PARITY_EN.
module reg_mem_2r1w #(
  parameter int unsigned     DATA_WIDTH  = 8,
  parameter int unsigned     ADDR_BITS   = 5,
  parameter longint unsigned CLEAR_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ren_a,
  input  logic [ADDR_BITS-1:0]  raddr_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  valid_a,
  input  logic                  ren_b,
  input  logic [ADDR_BITS-1:0]  raddr_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_b,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  perr_inject,
  output logic                  perr_a,
  output logic                  perr_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam logic [DATA_WIDTH-1:0] CLR_W =
    DATA_WIDTH'(CLEAR_VALUE);
  localparam logic [ADDR_BITS-1:0] LAST =
    ADDR_BITS'(DEPTH - 1);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ADDR_BITS-1:0] clr_ptr_q, clr_ptr_d;
  logic                 busy_q, busy_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  sweep;
  logic                  host_wr;
  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  mem_wp;

  // Host writes are dropped during a sweep and on the clr edge.
  assign sweep   = (state_q == CLEAR);
  assign host_wr = !sweep && wen && !clr;
  assign mem_we  = sweep || host_wr;
  assign mem_wa  = sweep ? clr_ptr_q : waddr;
  assign mem_wd  = sweep ? CLR_W : data_in;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (clr) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
          busy_d    = 1'b1;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_wa] <= mem_wd;
  end

`ifdef REG_MEM_PARITY_EN
  logic par_q [DEPTH];

  assign mem_wp = (^mem_wd) ^ (host_wr & perr_inject);

  always_ff @(posedge clk) begin
    if (!rst && mem_we) par_q[mem_wa] <= mem_wp;
  end
`else
  logic unused_inject;

  assign mem_wp        = 1'b0;
  assign unused_inject = perr_inject;
`endif

  logic [1:0]           ren;
  logic [ADDR_BITS-1:0] raddr [2];

  assign ren      = {ren_b, ren_a};
  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_perr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  perr_q;

    // Write-first: a same-cycle write (host or sweep) wins.
    assign hit = mem_we && (mem_wa == raddr[p]);

    always_comb begin
      rd_data = mem_q[raddr[p]];
      if (hit) rd_data = mem_wd;
    end

`ifdef REG_MEM_PARITY_EN
    logic rd_par;
    always_comb begin
      rd_par = par_q[raddr[p]];
      if (hit) rd_par = mem_wp;
    end
    assign rd_perr = (^rd_data) != rd_par;
`else
    logic unused_wp;
    assign unused_wp = mem_wp;
    assign rd_perr   = 1'b0;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
        perr_q  <= 1'b0;
      end else begin
        valid_q <= ren[p];
        perr_q  <= ren[p] & rd_perr;
        if (ren[p]) dout_q <= rd_data;
      end
    end
  end

  assign data_out_a = g_rd[0].dout_q;
  assign valid_a    = g_rd[0].valid_q;
  assign perr_a     = g_rd[0].perr_q;
  assign data_out_b = g_rd[1].dout_q;
  assign valid_b    = g_rd[1].valid_q;
  assign perr_b     = g_rd[1].perr_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reg_mem_2r1w.sv
// Scoreboard bench for reg_mem_2r1w: directed vectors,
// expected reads queued per port and popped by a monitor.
module tb_reg_mem_2r1w;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic [4:0] waddr = '0;
  logic [7:0] data_in = '0;
  logic       ren_a = 1'b0;
  logic [4:0] raddr_a = '0;
  logic [7:0] data_out_a;
  logic       valid_a;
  logic       ren_b = 1'b0;
  logic [4:0] raddr_b = '0;
  logic [7:0] data_out_b;
  logic       valid_b;
  logic       clr = 1'b0;
  logic       busy;
  logic       perr_inject = 1'b0;
  logic       perr_a;
  logic       perr_b;

`ifdef REG_MEM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;

  reg_mem_2r1w dut (
    .clk(clk), .rst(rst),
    .wen(wen), .waddr(waddr), .data_in(data_in),
    .ren_a(ren_a), .raddr_a(raddr_a),
    .data_out_a(data_out_a), .valid_a(valid_a),
    .ren_b(ren_b), .raddr_b(raddr_b),
    .data_out_b(data_out_b), .valid_b(valid_b),
    .clr(clr), .busy(busy),
    .perr_inject(perr_inject),
    .perr_a(perr_a), .perr_b(perr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input exp_t ea,
                    input logic [4:0] b, input exp_t eb,
                    input logic use_b);
    ren_a = 1'b1; raddr_a = a; qa.push_back(ea);
    ren_b = use_b; raddr_b = b;
    if (use_b) qb.push_back(eb);
    tick();
    ren_a = 1'b0; ren_b = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d,
                    input logic inj);
    wen = 1'b1; waddr = a; data_in = d; perr_inject = inj;
    tick();
    wen = 1'b0; perr_inject = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (valid_a) begin
      if (qa.size() == 0) begin
        chk("unexpected_valid_a", 1, 0);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("data_out_a", {24'h0, data_out_a}, {24'h0, e.d});
        chk("perr_a", {31'h0, perr_a}, {31'h0, e.p});
      end
    end
    if (valid_b) begin
      if (qb.size() == 0) begin
        chk("unexpected_valid_b", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("data_out_b", {24'h0, data_out_b}, {24'h0, e.d});
        chk("perr_b", {31'h0, perr_b}, {31'h0, e.p});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    tick();
    tick();
    chk("rst_busy", {31'h0, busy}, 1);
    chk("rst_valid_a", {31'h0, valid_a}, 0);
    chk("rst_dout_a", {24'h0, data_out_a}, 0);
    chk("rst_dout_b", {24'h0, data_out_b}, 0);
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_reset", n, 32);

    for (int a = 0; a < 32; a++)
      rd(5'(a), '{8'h00, 1'b0}, 5'(a), '{8'h00, 1'b0}, 1'b0);
    tick();

    for (int i = 1; i <= 29; i++) wr(5'(i + 2), 8'(i), 1'b0);
    for (int i = 1; i <= 29; i++)
      rd(5'(i + 2), '{8'(i), 1'b0},
         5'(31 - i), '{8'(29 - i), 1'b0}, 1'b1);
    tick();

    wen = 1'b1; waddr = 5'd7; data_in = 8'hA5;
    rd(5'd7, '{8'hA5, 1'b0}, 5'd7, '{8'hA5, 1'b0}, 1'b1);
    wen = 1'b0;
    rd(5'd7, '{8'hA5, 1'b0}, 5'd0, '{8'h00, 1'b0}, 1'b0);
    tick();

    wr(5'd3, 8'h5A, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_busy_rise", {31'h0, busy}, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      wen = (n == 10); waddr = 5'd3; data_in = 8'h77;
      clr = (n == 12);
      ren_a = (n == 20); raddr_a = 5'd19;
      if (n == 20) qa.push_back('{8'h00, 1'b0});
      tick();
    end
    wen = 1'b0; clr = 1'b0; ren_a = 1'b0;
    chk("busy_len_clr", n, 32);
    rd(5'd3, '{8'h00, 1'b0}, 5'd19, '{8'h00, 1'b0}, 1'b1);
    rd(5'd31, '{8'h00, 1'b0}, 5'd0, '{8'h00, 1'b0}, 1'b0);
    tick();

    wr(5'd5, 8'h11, 1'b0);
    rd(5'd5, '{8'h11, 1'b0}, 5'd5, '{8'h11, 1'b0}, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    rst = 1'b1; ren_a = 1'b1; ren_b = 1'b1;
    tick();
    ren_a = 1'b0; ren_b = 1'b0;
    chk("midrst_busy", {31'h0, busy}, 1);
    chk("midrst_valid_a", {31'h0, valid_a}, 0);
    chk("midrst_valid_b", {31'h0, valid_b}, 0);
    chk("midrst_dout_a", {24'h0, data_out_a}, 0);
    chk("midrst_dout_b", {24'h0, data_out_b}, 0);
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_midrst", n, 32);
    rd(5'd5, '{8'h00, 1'b0}, 5'd9, '{8'h00, 1'b0}, 1'b1);
    tick();

    wr(5'd4, 8'h3C, 1'b1);
    wr(5'd5, 8'h3C, 1'b0);
    rd(5'd4, '{8'h3C, PAR}, 5'd5, '{8'h3C, 1'b0}, 1'b1);
    rd(5'd5, '{8'h3C, 1'b0}, 5'd4, '{8'h3C, PAR}, 1'b1);
    wen = 1'b1; waddr = 5'd6; data_in = 8'h3C;
    perr_inject = 1'b1;
    rd(5'd0, '{8'h00, 1'b0}, 5'd6, '{8'h3C, PAR}, 1'b1);
    wen = 1'b0; perr_inject = 1'b0;
    tick();
    tick();

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
